// File: rtl/cr_lz77_comp_ob_rx.sv
// Receive endpoint for the LZ77 compressor output stream: 2-entry skid buffer, per-frame
// byte/word counting, protocol error flags and a credit-style summary. Optional macro: CR_LZ77_COMP_OB_RX_STRB_CHECK_EN.
module cr_lz77_comp_ob_rx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic [63:0] in_tdata,
    input  logic [7:0]  in_tstrb,
    input  logic [7:0]  in_tuser,
    input  logic        in_tlast,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic [63:0] out_tdata,
    output logic [7:0]  out_tstrb,
    output logic [7:0]  out_tuser,
    output logic        out_tlast,
    output logic        sum_valid,
    input  logic        sum_ready,
    output logic [23:0] sum_bytes,
    output logic [20:0] sum_words,
    output logic [3:0]  sum_err,
    output logic        stat_frame,
    output logic        stat_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, PEND = 2'd2} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [7:0]  user;
        logic        last;
    } beat_t;

    beat_t       ent0, ent1, in_beat;
    logic [1:0]  count;
    logic        alive;
    logic        push, pop;
    state_t      state, state_nx;

    logic [23:0] acc_bytes, acc_bytes_nx, beat_bytes, ld_bytes;
    logic [20:0] acc_words, acc_words_nx, beat_words, ld_words;
    logic [3:0]  acc_err, acc_err_nx, beat_err, ld_err;
    logic [24:0] bytes_sum;
    logic [3:0]  pc;
    logic        load, strb_bad, sot;

    assign in_beat    = {in_tdata, in_tstrb, in_tuser, in_tlast};
    assign in_tready  = alive && (count != 2'd2) && (state != PEND);
    assign out_tvalid = (count != 2'd0);
    assign {out_tdata, out_tstrb, out_tuser, out_tlast} = ent0;
    assign push = in_tvalid && in_tready;
    assign pop  = out_tvalid && out_tready;
    assign sot  = in_tuser[0];

`ifdef CR_LZ77_COMP_OB_RX_STRB_CHECK_EN
    logic [7:0] strb_inc;
    assign strb_inc = in_tstrb + 8'd1;
    // Last beat must be a contiguous low-aligned mask 2^k-1 (k>=1).
    assign strb_bad = in_tlast ? ((in_tstrb == 8'h00) || ((in_tstrb & strb_inc) != 8'h00))
                               : (in_tstrb != 8'hFF);
`else
    assign strb_bad = 1'b0;
`endif

    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            pc = pc + {3'b000, in_tstrb[i]};
        end
    end

    // Skid buffer; ent0 is the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= '0;
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= in_beat;
                    else               ent1 <= in_beat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= in_beat;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= in_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_bytes <= '0;
            acc_words <= '0;
            acc_err   <= '0;
        end else begin
            state     <= state_nx;
            acc_bytes <= acc_bytes_nx;
            acc_words <= acc_words_nx;
            acc_err   <= acc_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        acc_bytes_nx = acc_bytes;
        acc_words_nx = acc_words;
        acc_err_nx   = acc_err;
        load         = 1'b0;
        ld_bytes     = acc_bytes;
        ld_words     = acc_words;
        ld_err       = acc_err;
        bytes_sum    = {1'b0, acc_bytes} + {21'd0, pc};
        beat_bytes   = {20'd0, pc};
        beat_words   = 21'd1;
        beat_err     = {1'b0, strb_bad, 1'b0, ~sot};
        if (state == FRAME) begin
            beat_bytes = bytes_sum[24] ? '1 : bytes_sum[23:0];
            beat_words = (acc_words == '1) ? acc_words : acc_words + 21'd1;
            beat_err   = acc_err | {bytes_sum[24] || (acc_words == '1), strb_bad, sot, 1'b0};
        end
        case (state)
            IDLE, FRAME: begin
                if (push) begin
                    acc_bytes_nx = beat_bytes;
                    acc_words_nx = beat_words;
                    acc_err_nx   = beat_err;
                    if (in_tlast) begin
                        if (!sum_valid || sum_ready) begin
                            load     = 1'b1;
                            ld_bytes = beat_bytes;
                            ld_words = beat_words;
                            ld_err   = beat_err;
                            state_nx = IDLE;
                        end else begin
                            state_nx = PEND;
                        end
                    end else begin
                        state_nx = FRAME;
                    end
                end
            end
            PEND: begin
                if (sum_ready) begin
                    load     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_valid  <= 1'b0;
            sum_bytes  <= '0;
            sum_words  <= '0;
            sum_err    <= '0;
            stat_frame <= 1'b0;
            stat_err   <= 1'b0;
        end else begin
            stat_frame <= load;
            stat_err   <= load && (ld_err != '0);
            if (load) begin
                sum_valid <= 1'b1;
                sum_bytes <= ld_bytes;
                sum_words <= ld_words;
                sum_err   <= ld_err;
            end else if (sum_ready) begin
                sum_valid <= 1'b0;
            end
        end
    end
endmodule
